// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bundle: decode/execute/memory status from the
// datapath and the register enable/flush/bubble controls back to it.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_load;
  logic [4:0]  ex_dest;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_enable;
  logic        if_id_enable;
  logic        if_id_flush;
  logic        id_ex_enable;
  logic        id_ex_bubble;
  logic        ex_mem_enable;
  logic        mem_error;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_dest,
           ex_redirect, mem_req, mem_ready,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble,
           ex_mem_enable, mem_error, state, stall_cycles, flush_events
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_load, ex_dest,
           ex_redirect, mem_req, mem_ready,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble,
           ex_mem_enable, mem_error, state, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Optional performance counters are built when PIPE_PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic clock,
  input  logic reset_n,
  pipeline_hazard_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifid_en;
    logic ifid_fl;
    logic idex_en;
    logic idex_bub;
    logic exmem_en;
  } ctl_t;

  localparam ctl_t CTL_OFF    = ctl_t'(6'b000000);
  localparam ctl_t CTL_RUN    = ctl_t'(6'b110101);
  localparam ctl_t CTL_FLUSH  = ctl_t'(6'b111111);
  localparam ctl_t CTL_HAZARD = ctl_t'(6'b000111);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] flush_q, flush_d;
  logic       err_q, err_d;
  ctl_t       ctl;
  logic       freeze;
  logic       hazard;

  assign freeze = bus.mem_req & ~bus.mem_ready;
  assign hazard = bus.ex_load & (bus.ex_dest != 5'd0) &
                  ((bus.id_uses_rs & (bus.id_rs == bus.ex_dest)) |
                   (bus.id_uses_rt & (bus.id_rt == bus.ex_dest)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a default up front so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    flush_d = flush_q;
    err_d   = err_q;
    ctl     = CTL_OFF;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else if (bus.ex_redirect) begin
          ctl = CTL_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            flush_d = FLUSH_INIT;
          end
        end else if (hazard) begin
          ctl = CTL_HAZARD;
        end else begin
          ctl = CTL_RUN;
        end
      end
      MEM_WAIT: begin
        // Redirect/hazard wait for RUN so the completing access retires first.
        if (bus.mem_ready) begin
          ctl     = CTL_RUN;
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      FLUSH: begin
        if (!freeze) begin
          ctl     = CTL_FLUSH;
          flush_d = flush_q - 4'd1;
          if (flush_q == 4'd1) state_d = RUN;
        end
      end
      HALT: begin
        ctl = CTL_OFF;
      end
    endcase
    if (!reset_n) ctl = CTL_OFF;
  end

  assign bus.pc_enable     = ctl.pc;
  assign bus.if_id_enable  = ctl.ifid_en;
  assign bus.if_id_flush   = ctl.ifid_fl;
  assign bus.id_ex_enable  = ctl.idex_en;
  assign bus.id_ex_bubble  = ctl.idex_bub;
  assign bus.ex_mem_enable = ctl.exmem_en;
  assign bus.state         = state_q;
  assign bus.mem_error     = err_q;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_q;
  logic [31:0] flush_ev_q;
  logic        accept;

  assign accept = (state_q == RUN) & ~freeze & bus.ex_redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q    <= '0;
      flush_ev_q <= '0;
    end else begin
      if (!ctl.pc && state_q != HALT) stall_q <= stall_q + 32'd1;
      if (accept) flush_ev_q <= flush_ev_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_ev_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4:
// single-cycle vector table plus multi-cycle stall/flush/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_FL = 2'd2, S_HALT = 2'd3;
  // Control order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en
  localparam logic [5:0] C_OFF = 6'b000000, C_RUN = 6'b110101;
  localparam logic [5:0] C_FL  = 6'b111111, C_HZ  = 6'b000111;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       ex_load;
    logic [4:0] ex_dest;
    logic       redirect;
    logic       mem_req;
    logic       mem_ready;
  } in_t;

  typedef struct packed {
    logic [5:0] ctl;
    logic [1:0] state;
    logic       err;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int    checks = 0;
  int    failures = 0;
  int    exp_stall = 0;
  int    exp_flush = 0;
  exp_t  sb_q[$];
  string sb_name[$];
  vec_t  tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                             input logic urt, input logic ld, input logic [4:0] dest,
                             input logic red, input logic req, input logic rdy);
    return '{rs, rt, urs, urt, ld, dest, red, req, rdy};
  endfunction

  function automatic exp_t ex(input logic [5:0] c, input logic [1:0] s, input logic e);
    return '{c, s, e};
  endfunction

  function automatic exp_t observed();
    return '{{bus.pc_enable, bus.if_id_enable, bus.if_id_flush, bus.id_ex_enable,
              bus.id_ex_bubble, bus.ex_mem_enable}, bus.state, bus.mem_error};
  endfunction

  task automatic apply(input in_t v);
    bus.id_rs       = v.rs;
    bus.id_rt       = v.rt;
    bus.id_uses_rs  = v.uses_rs;
    bus.id_uses_rt  = v.uses_rt;
    bus.ex_load     = v.ex_load;
    bus.ex_dest     = v.ex_dest;
    bus.ex_redirect = v.redirect;
    bus.mem_req     = v.mem_req;
    bus.mem_ready   = v.mem_ready;
  endtask

  task automatic expect_now(input string name, input exp_t e);
    sb_q.push_back(e);
    sb_name.push_back(name);
  endtask

  // Pops the oldest expectation; 'count' folds it into the counter model.
  task automatic compare_now(input bit count);
    exp_t  e;
    string n;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    n = sb_name.pop_front();
    check(n, 32'(observed()), 32'(e));
    if (count) begin
      if (!e.ctl[5] && e.state != S_HALT) exp_stall++;
      if (e.state == S_RUN && e.ctl[3]) exp_flush++;
    end
  endtask

  task automatic step(input string name, input in_t v, input exp_t e);
    apply(v);
    expect_now(name, e);
    #1;
    compare_now(1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_counters(input string name);
`ifdef PIPE_PERF_COUNTERS_EN
    check({name, " stall_cycles"}, bus.stall_cycles, 32'(exp_stall));
    check({name, " flush_events"}, bus.flush_events, 32'(exp_flush));
`else
    check({name, " stall_cycles"}, bus.stall_cycles, 32'd0);
    check({name, " flush_events"}, bus.flush_events, 32'd0);
`endif
  endtask

  task automatic assert_reset(input string name);
    reset_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    expect_now({name, " async"}, ex(C_OFF, S_RUN, 1'b0));
    compare_now(1'b0);
    @(posedge clock);
    #1;
    expect_now({name, " held"}, ex(C_OFF, S_RUN, 1'b0));
    compare_now(1'b0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  in_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    tbl[0] = '{"idle",          idle,                                 ex(C_RUN, S_RUN, 0)};
    tbl[1] = '{"load_use_rt",   mk(5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0), ex(C_HZ,  S_RUN, 0)};
    tbl[2] = '{"after_hazard",  mk(5'd1, 5'd5, 0, 1, 0, 5'd5, 0, 0, 0), ex(C_RUN, S_RUN, 0)};
    tbl[3] = '{"load_use_rs",   mk(5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 0, 0), ex(C_HZ,  S_RUN, 0)};
    tbl[4] = '{"rs_not_used",   mk(5'd7, 5'd2, 0, 1, 1, 5'd7, 0, 0, 0), ex(C_RUN, S_RUN, 0)};
    tbl[5] = '{"zero_reg",      mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0), ex(C_RUN, S_RUN, 0)};
    tbl[6] = '{"no_load",       mk(5'd9, 5'd9, 1, 1, 0, 5'd9, 0, 0, 0), ex(C_RUN, S_RUN, 0)};
    tbl[7] = '{"rt_mismatch",   mk(5'd3, 5'd6, 1, 1, 1, 5'd5, 0, 0, 0), ex(C_RUN, S_RUN, 0)};
    tbl[8] = '{"mem_ready_hit", mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1), ex(C_RUN, S_RUN, 0)};
    tbl[9] = '{"hazard_mem_ok", mk(5'd31, 5'd4, 1, 0, 1, 5'd31, 0, 1, 1), ex(C_HZ, S_RUN, 0)};

    apply(idle);
    reset_n = 1'b0;
    #2;
    expect_now("reset_state", ex(C_OFF, S_RUN, 1'b0));
    compare_now(1'b0);
    check_counters("reset");
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 10; i++) step(tbl[i].name, tbl[i].in, tbl[i].exp);
    check_counters("table");

    // Redirect: three bubble cycles; redirect and hazard in FLUSH are ignored.
    step("redir_accept",  mk(0, 0, 0, 0, 0, 0, 1, 0, 0), ex(C_FL,  S_RUN, 0));
    step("redir_flush1",  mk(0, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0), ex(C_FL, S_FL, 0));
    step("redir_flush2",  idle, ex(C_FL,  S_FL,  0));
    step("redir_done",    idle, ex(C_RUN, S_RUN, 0));
    check_counters("redirect");

    // Freeze inside FLUSH holds the flush counter.
    step("fzfl_accept",   mk(0, 0, 0, 0, 0, 0, 1, 0, 0), ex(C_FL,  S_RUN, 0));
    step("fzfl_freeze",   mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_FL,  0));
    step("fzfl_flush_a",  idle, ex(C_FL,  S_FL,  0));
    step("fzfl_flush_b",  idle, ex(C_FL,  S_FL,  0));
    step("fzfl_done",     idle, ex(C_RUN, S_RUN, 0));

    // Freeze beats redirect; redirect acted on only after returning to RUN.
    step("fzrd_freeze",   mk(0, 0, 0, 0, 0, 0, 1, 1, 0), ex(C_OFF, S_RUN, 0));
    step("fzrd_wait1",    mk(0, 0, 0, 0, 0, 0, 1, 1, 0), ex(C_OFF, S_MW,  0));
    step("fzrd_wait2",    mk(0, 0, 0, 0, 0, 0, 1, 1, 0), ex(C_OFF, S_MW,  0));
    step("fzrd_ready",    mk(0, 0, 0, 0, 0, 0, 1, 1, 1), ex(C_RUN, S_MW,  0));
    step("fzrd_redirect", mk(0, 0, 0, 0, 0, 0, 1, 0, 0), ex(C_FL,  S_RUN, 0));
    step("fzrd_flush1",   idle, ex(C_FL,  S_FL,  0));
    step("fzrd_flush2",   idle, ex(C_FL,  S_FL,  0));
    step("fzrd_done",     idle, ex(C_RUN, S_RUN, 0));
    check_counters("freeze_redirect");

    // Reset during the second flush cycle.
    step("rstfl_accept",  mk(0, 0, 0, 0, 0, 0, 1, 0, 0), ex(C_FL, S_RUN, 0));
    step("rstfl_flush1",  idle, ex(C_FL, S_FL, 0));
    apply(idle);
    #1;
    expect_now("rstfl_flush2", ex(C_FL, S_FL, 0));
    compare_now(1'b1);
    assert_reset("rstfl_reset");
    check_counters("rstfl_cleared");
    step("rstfl_resume1", idle, ex(C_RUN, S_RUN, 0));
    step("rstfl_resume2", idle, ex(C_RUN, S_RUN, 0));

    // Memory timeout: HALT after four stall cycles, sticky until reset.
    step("to_freeze",     mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_RUN,  0));
    step("to_wait1",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_MW,   0));
    step("to_wait2",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_MW,   0));
    step("to_wait3",      mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_MW,   0));
    step("to_halt",       mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(C_OFF, S_HALT, 1));
    step("to_halt_ready", mk(0, 0, 0, 0, 0, 0, 1, 1, 1), ex(C_OFF, S_HALT, 1));
    step("to_halt_idle",  idle, ex(C_OFF, S_HALT, 1));
    check_counters("timeout");
    assert_reset("to_reset");
    step("to_recovered",  idle, ex(C_RUN, S_RUN, 0));
    check_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
